// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module : pc_pkg
// Brief  : Shared types and helpers for the fetch-stage program-counter unit.
// Rev    : 1.0  initial release
// ============================================================================
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ   = 3'd0,
        SEL_FLUSH = 3'd1,
        SEL_HOLD  = 3'd2,
        SEL_J     = 3'd3,
        SEL_JR    = 3'd4,
        SEL_BRA   = 3'd5,
        SEL_JALR  = 3'd6
    } pc_sel_e;

    // Pointer width for a RAS of the given depth; never narrower than one bit.
    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pc_ctrl_if
// Brief  : Fetch-side request/response bundle of the program-counter unit.
// Rev    : 1.0  initial release
// ============================================================================
interface pc_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              j;
    logic              jr;
    logic              bra;
    logic              jalr;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] jr_addr;
    logic [ADDR_W-1:0] bra_addr;
    logic [ADDR_W-1:0] jalr_addr;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_overflow;
    logic              ras_underflow;
    logic [CNT_W-1:0]  redirect_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output stall, flush, j, jr, bra, jalr,
        output jump_addr, jr_addr, bra_addr, jalr_addr,
        output call, ret,
        input  pc, pc_next, ras_top, ras_empty, ras_full,
        input  ras_overflow, ras_underflow, redirect_cnt, stall_cnt
    );

    modport slave (
        input  stall, flush, j, jr, bra, jalr,
        input  jump_addr, jr_addr, bra_addr, jalr_addr,
        input  call, ret,
        output pc, pc_next, ras_top, ras_empty, ras_full,
        output ras_overflow, ras_underflow, redirect_cnt, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module : ras_stack
// Brief  : Circular return-address stack; a push when full overwrites the oldest.
// Rev    : 1.0  initial release
// ============================================================================
module ras_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push_i,
    input  wire logic              pop_i,
    input  wire logic [ADDR_W-1:0] push_val_i,
    output logic      [ADDR_W-1:0] top_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int PTR_W    = ras_ptr_w(RAS_DEPTH);
    localparam int CNT_BITS = PTR_W + 1;
    localparam logic [PTR_W-1:0]    PTR_ONE = PTR_W'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(RAS_DEPTH);

    logic [ADDR_W-1:0]   mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0]   mem_d [RAS_DEPTH];
    logic [PTR_W-1:0]    tp_q, tp_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic [PTR_W-1:0]    w_tp_inc;
    logic [PTR_W-1:0]    w_tp_dec;
    logic                w_empty;
    logic                w_full;

    assign w_tp_inc = tp_q + PTR_ONE;
    assign w_tp_dec = tp_q - PTR_ONE;
    assign w_empty  = (cnt_q == '0);
    assign w_full   = (cnt_q == DEPTH_C);

    // The pointer wraps naturally because the depth is a power of two, so a
    // push when full lands on the oldest slot without extra bookkeeping.
    always_comb begin
        mem_d = mem_q;
        tp_d  = tp_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (push_i && pop_i) begin
            if (w_empty) begin
                tp_d            = w_tp_inc;
                mem_d[w_tp_inc] = push_val_i;
                cnt_d           = CNT_ONE;
            end else begin
                mem_d[tp_q] = push_val_i;
            end
        end else if (push_i) begin
            tp_d            = w_tp_inc;
            mem_d[w_tp_inc] = push_val_i;
            if (w_full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (pop_i) begin
            if (w_empty) begin
                unf_d = 1'b1;
            end else begin
                tp_d  = w_tp_dec;
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            tp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign top_o       = w_empty ? '0 : mem_q[tp_q];
    assign empty_o     = w_empty;
    assign full_o      = w_full;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pc_ctrl
// Brief  : Fetch-stage program counter with prioritised redirects, stall/flush
//          and a return-address stack. Optional PC_PERF_COUNT_EN adds
//          saturating redirect and stall counters.
// Rev    : 1.0  initial release
// ============================================================================
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 8'hF0,
    parameter int                RAS_DEPTH = 4,
    parameter int                CNT_W     = 16
) (
    input wire logic   clk,
    input wire logic   rst,
    pc_ctrl_if.slave   bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_ras_ok;

    assign w_pc_inc = pc_q + ADDR_ONE;

    always_comb begin
        sel = SEL_SEQ;
        if (bus.flush)      sel = SEL_FLUSH;
        else if (bus.stall) sel = SEL_HOLD;
        else if (bus.j)     sel = SEL_J;
        else if (bus.jr)    sel = SEL_JR;
        else if (bus.bra)   sel = SEL_BRA;
        else if (bus.jalr)  sel = SEL_JALR;
    end

    // Reset is folded in so pc_next always names the value of the next edge.
    always_comb begin
        pc_d = w_pc_inc;
        case (sel)
            SEL_FLUSH: pc_d = EXC_VEC;
            SEL_HOLD:  pc_d = pc_q;
            SEL_J:     pc_d = bus.jump_addr;
            SEL_JR:    pc_d = bus.jr_addr;
            SEL_BRA:   pc_d = bus.bra_addr;
            SEL_JALR:  pc_d = bus.jalr_addr;
            default:   pc_d = w_pc_inc;
        endcase
        if (rst) begin
            pc_d = RESET_VEC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.pc_next = pc_d;

    assign w_ras_ok = ~bus.stall & ~bus.flush;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.call & w_ras_ok),
        .pop_i       (bus.ret & w_ras_ok),
        .push_val_i  (w_pc_inc),
        .top_o       (bus.ras_top),
        .empty_o     (bus.ras_empty),
        .full_o      (bus.ras_full),
        .overflow_o  (bus.ras_overflow),
        .underflow_o (bus.ras_underflow)
    );

`ifdef PC_PERF_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             w_redirect;

    assign w_redirect = (sel != SEL_SEQ) && (sel != SEL_HOLD);

    always_comb begin
        redir_cnt_d = redir_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (w_redirect && (redir_cnt_q != '1)) begin
            redir_cnt_d = redir_cnt_q + CNT_ONE;
        end
        if ((sel == SEL_HOLD) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redir_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            redir_cnt_q <= redir_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.redirect_cnt = redir_cnt_q;
    assign bus.stall_cnt    = stall_cnt_q;
`else
    assign bus.redirect_cnt = '0;
    assign bus.stall_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter unit for the fetch stage. It selects the next PC from a sequential increment, four prioritised redirect sources and an exception vector. It adds stall and flush handling, and a small return-address stack (RAS) that tracks call/return nesting. The registered PC feeds instruction memory; the RAS top feeds the decode/branch logic as a return-target hint.

Parameters:
ADDR_W, 8, PC and all address widths in bits
RESET_VEC, 0, PC value loaded on reset (ADDR_W bits)
EXC_VEC, 8'hF0, PC value loaded on flush (ADDR_W bits)
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)
CNT_W, 16, width of optional performance counters

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  1  hold PC and RAS this cycle
flush  in  1  exception redirect to EXC_VEC
j, jr, bra, jalr  in  1 each  redirect requests
jump_addr, jr_addr, bra_addr, jalr_addr  in  ADDR_W each  redirect targets
call  in  1  link instruction at current PC: push pc+1
ret  in  1  return instruction: pop RAS
pc  out  ADDR_W  registered program counter
pc_next  out  ADDR_W  combinational value pc takes at next edge
ras_top  out  ADDR_W  current RAS top entry, 0 when empty
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_overflow  out  1  one-cycle pulse: push dropped the oldest entry
ras_underflow  out  1  one-cycle pulse: pop attempted on an empty RAS
redirect_cnt  out  CNT_W  redirects taken (optional feature)
stall_cnt  out  CNT_W  stalled cycles (optional feature)

Behaviour:
- Reset: clk and rst are synchronous, active-high. On reset: pc=RESET_VEC, RAS count=0, ras_top=0, ras_empty=1, ras_full=0, pulses=0, counters=0. Reset overrides all other inputs, including mid-stall and mid-flush.
- Next-PC priority, one cycle latency, evaluated each posedge: rst > flush > stall > j > jr > bra > jalr > sequential.
  - flush: pc<=EXC_VEC.
  - stall: pc holds.
  - sequential: pc<=pc+1, modulo 2^ADDR_W; all-ones wraps to 0.
- pc_next shows exactly the value selected for the next edge, pc included when holding.
- Only the highest-priority redirect is taken; lower-priority requests that cycle are dropped, not queued.
- RAS operations are qualified: a push or pop occurs only when call/ret is high and stall=0, flush=0. When flush=1 or stall=1, call/ret are ignored and RAS contents are unchanged.
- Push value is pc+1, wrapped to ADDR_W bits.
- Push when full: circular overwrite of the oldest entry. Count stays at RAS_DEPTH; ras_overflow pulses for 1 cycle.
- Pop when empty: no state change; ras_underflow pulses for 1 cycle.
- call and ret in the same cycle: the top entry is replaced by pc+1 and count is unchanged. This also applies when full. When empty, it acts as a push with no underflow pulse.
- ras_top, ras_empty and ras_full are registered state and reflect the RAS after the last edge.
- RAS state is independent of which redirect is taken; callers assert call together with j/jalr as needed.

Optional Feature:
- Macro: PC_PERF_COUNT_EN.
- Defined:
  - redirect_cnt increments on every cycle that takes flush or any of j/jr/bra/jalr.
  - stall_cnt increments on every cycle with stall=1 and no flush/rst.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports stay present, tied to 0, and no counter flops are built.

Decomposition:
- Package pc_pkg holds:
  - enum pc_sel_e {SEL_SEQ, SEL_FLUSH, SEL_HOLD, SEL_J, SEL_JR, SEL_BRA, SEL_JALR}
  - a localparam helper for the RAS pointer width, $clog2(RAS_DEPTH)
- Sub-module ras_stack: circular buffer with push/pop/both, count, overflow/underflow pulses, parametrised by ADDR_W and RAS_DEPTH. pc_ctrl instantiates it and holds the priority mux and PC register.

Test Plan:
All tests use ADDR_W=8, RAS_DEPTH=4, RESET_VEC=0, EXC_VEC=8'hF0.
1. Reset, then 3 idle cycles -> pc 0,1,2,3. Set pc=8'hFF, idle 1 cycle -> pc=8'h00, no other state change.
2. pc=8'h10 with j=1, jr=1, bra=1 (targets 8'h40, 8'h50, 8'h60) -> pc=8'h40. Same request with stall=1 -> pc stays 8'h10. Add flush=1 -> pc=8'hF0.
3. call at pc 8'h05, 8'h20, 8'h30, 8'h40, 8'h50 (five pushes) -> ras_full=1 after the 4th push. 5th push pulses ras_overflow; ras_top=8'h51. Then 4 pops -> tops 8'h41, 8'h31, 8'h21, then 0 with ras_empty=1; entry 8'h06 is lost.
4. Empty RAS, ret=1 -> ras_underflow pulses 1 cycle, ras_empty stays 1. Then call+ret together at pc=8'h33 -> ras_top=8'h34, count 1.
5. call=1 with stall=1, then call=1 with flush=1 -> RAS unchanged in both cycles. Assert rst while stall=1 -> pc=0 and RAS empty next cycle.
6. With PC_PERF_COUNT_EN defined: 2 j redirects, 1 flush, 3 stall cycles -> redirect_cnt=3, stall_cnt=3. With the macro undefined, both read 0.
